// File: rtl/i4002_pkg.sv
// Shared constants and types for the i4002 RAM secondary-read arbiter.
package i4002_pkg;

    localparam int unsigned RAM_ADDR_W = 5;
    localparam int unsigned RAM_DATA_W = 4;
    localparam int unsigned NUM_REGS   = 4;

    localparam logic [RAM_ADDR_W-1:0] STATUS_BASE = 5'h10;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

endpackage

// File: rtl/i4002_rd_arbiter_rr.sv
// Combinational round-robin picker: first set request after last_i, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [1:0]         last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               valid_o
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IdxW-1:0] idx;

    always_comb begin
        gnt_o   = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            idx = IdxW'((int'(last_i) + k) % int'(NUM_REQ));
            if (!valid_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                valid_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i4002_rd_arbiter.sv
// Shares the four i4002 secondary read ports among NUM_REQ requesters, one read per grant.
module i4002_rd_arbiter
    import i4002_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned RAM_ARRAY_SIZE = 32
) (
    input  logic                            sysclk_i,
    input  logic                            reset_i,
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [2*NUM_REQ-1:0]            req_reg_i,
    input  logic [RAM_ADDR_W*NUM_REQ-1:0]   req_addr_i,
    output logic [NUM_REQ-1:0]              gnt_o,
    output logic                            rd_valid_o,
    output logic [RAM_DATA_W-1:0]           rd_data_o,
    output logic [1:0]                      rd_id_o,
    output logic                            rd_err_o,
    output logic                            busy_o,
    output logic [RAM_ADDR_W-1:0]           ram0_addr2_o,
    output logic [RAM_ADDR_W-1:0]           ram1_addr2_o,
    output logic [RAM_ADDR_W-1:0]           ram2_addr2_o,
    output logic [RAM_ADDR_W-1:0]           ram3_addr2_o,
    input  logic [RAM_DATA_W-1:0]           ram0_data2_out_i,
    input  logic [RAM_DATA_W-1:0]           ram1_data2_out_i,
    input  logic [RAM_DATA_W-1:0]           ram2_data2_out_i,
    input  logic [RAM_DATA_W-1:0]           ram3_data2_out_i
);

    state_t                  state_q, state_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic [NUM_REQ-1:0]      eligible, win_oh;
    logic                    win_valid;
    logic [1:0]              last_q, last_d;
    logic [1:0]              sel_reg_q, sel_reg_d;
    logic [1:0]              sel_id_q, sel_id_d;
    logic                    sel_err_q, sel_err_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [RAM_DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [1:0]              rd_id_q, rd_id_d;
    logic                    rd_err_q, rd_err_d;
    logic [RAM_ADDR_W-1:0]   addr_q [NUM_REGS];
    logic [RAM_ADDR_W-1:0]   addr_d [NUM_REGS];
    logic [RAM_DATA_W-1:0]   ram_data [NUM_REGS];
    logic [1:0]              win_reg, win_id;
    logic [RAM_ADDR_W-1:0]   win_addr;

    // A requester still seeing its grant pulse is not eligible again this edge.
    assign eligible = req_i & ~gnt_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req_i   (eligible),
        .last_i  (last_q),
        .gnt_o   (win_oh),
        .valid_o (win_valid)
    );

    assign ram_data[0] = ram0_data2_out_i;
    assign ram_data[1] = ram1_data2_out_i;
    assign ram_data[2] = ram2_data2_out_i;
    assign ram_data[3] = ram3_data2_out_i;

    always_comb begin
        win_reg  = '0;
        win_addr = '0;
        win_id   = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (win_oh[i]) begin
                win_reg  = req_reg_i[2*i +: 2];
                win_addr = req_addr_i[RAM_ADDR_W*i +: RAM_ADDR_W];
                win_id   = 2'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = '0;
        last_d     = last_q;
        sel_reg_d  = sel_reg_q;
        sel_id_d   = sel_id_q;
        sel_err_d  = sel_err_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        rd_id_d    = rd_id_q;
        rd_err_d   = rd_err_q;
        addr_d     = addr_q;

        if (state_q == READ) begin
            rd_valid_d = 1'b1;
            rd_id_d    = sel_id_q;
            rd_err_d   = sel_err_q;
            rd_data_d  = sel_err_q ? '0 : ram_data[sel_reg_q];
            state_d    = IDLE;
        end

        // A grant is issued from either state; in READ it overlaps the capture.
        if (win_valid) begin
            gnt_d          = win_oh;
            last_d         = win_id;
            sel_reg_d      = win_reg;
            sel_id_d       = win_id;
            sel_err_d      = 32'(win_addr) >= RAM_ARRAY_SIZE;
            addr_d[win_reg] = win_addr;
            state_d        = READ;
        end
    end

    always_ff @(posedge sysclk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            last_q     <= 2'(NUM_REQ - 1);
            sel_reg_q  <= '0;
            sel_id_q   <= '0;
            sel_err_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_id_q    <= '0;
            rd_err_q   <= 1'b0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            sel_reg_q  <= sel_reg_d;
            sel_id_q   <= sel_id_d;
            sel_err_q  <= sel_err_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            rd_id_q    <= rd_id_d;
            rd_err_q   <= rd_err_d;
            addr_q     <= addr_d;
        end
    end

    assign gnt_o        = gnt_q;
    assign rd_valid_o   = rd_valid_q;
    assign rd_data_o    = rd_data_q;
    assign rd_id_o      = rd_id_q;
    assign rd_err_o     = rd_err_q;
    assign busy_o       = (state_q == READ);
    assign ram0_addr2_o = addr_q[0];
    assign ram1_addr2_o = addr_q[1];
    assign ram2_addr2_o = addr_q[2];
    assign ram3_addr2_o = addr_q[3];

endmodule

// File: tb/tb_i4002_rd_arbiter.sv
// Bench for i4002_rd_arbiter: vector table plus fairness, mask and async-reset sequences.
module tb_i4002_rd_arbiter;

    localparam int unsigned NREQ  = 2;
    localparam int unsigned RSIZE = 20;

    typedef struct {
        int         id;
        logic [1:0] rreg;
        logic [4:0] addr;
        logic [3:0] exp_data;
        logic       exp_err;
    } vec_t;

    typedef struct {
        logic [1:0] id;
        logic [3:0] data;
        logic       err;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic [3:0] req_reg;
    logic [9:0] req_addr;
    logic [1:0] gnt;
    logic       rd_valid;
    logic [3:0] rd_data;
    logic [1:0] rd_id;
    logic       rd_err;
    logic       busy;
    logic [4:0] ram_addr [4];
    logic [3:0] ram_dout [4];

    logic [3:0] mem [4][32];
    logic [4:0] exp_addr [4];
    exp_t       sb [$];
    vec_t       vecs [8];
    int         total;
    int         bad;

    i4002_rd_arbiter #(
        .NUM_REQ        (NREQ),
        .RAM_ARRAY_SIZE (RSIZE)
    ) dut (
        .sysclk_i         (clk),
        .reset_i          (reset),
        .req_i            (req),
        .req_reg_i        (req_reg),
        .req_addr_i       (req_addr),
        .gnt_o            (gnt),
        .rd_valid_o       (rd_valid),
        .rd_data_o        (rd_data),
        .rd_id_o          (rd_id),
        .rd_err_o         (rd_err),
        .busy_o           (busy),
        .ram0_addr2_o     (ram_addr[0]),
        .ram1_addr2_o     (ram_addr[1]),
        .ram2_addr2_o     (ram_addr[2]),
        .ram3_addr2_o     (ram_addr[3]),
        .ram0_data2_out_i (ram_dout[0]),
        .ram1_data2_out_i (ram_dout[1]),
        .ram2_data2_out_i (ram_dout[2]),
        .ram3_data2_out_i (ram_dout[3])
    );

    assign ram_dout[0] = mem[0][ram_addr[0]];
    assign ram_dout[1] = mem[1][ram_addr[1]];
    assign ram_dout[2] = mem[2][ram_addr[2]];
    assign ram_dout[3] = mem[3][ram_addr[3]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] model(input logic [1:0] r, input logic [4:0] a);
        return (32'(a) >= RSIZE) ? 4'h0 : mem[r][a];
    endfunction

    task automatic monitor();
        exp_t e;
        if (rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rd_valid: got rd_id=%0d with empty scoreboard", rd_id);
            end else begin
                e = sb.pop_front();
                check("rd_id", 32'(rd_id), 32'(e.id));
                check("rd_data", 32'(rd_data), 32'(e.data));
                check("rd_err", 32'(rd_err), 32'(e.err));
            end
        end
    endtask

    // Monitor at the falling edge, then return 1 ns after the next rising edge.
    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input logic [1:0] r, input logic [4:0] a);
        exp_t e;
        e.id   = 2'(id);
        e.data = model(r, a);
        e.err  = 32'(a) >= RSIZE;
        sb.push_back(e);
        exp_addr[r] = a;
    endtask

    task automatic check_ports(input string name);
        check(name, 32'({ram_addr[3], ram_addr[2], ram_addr[1], ram_addr[0]}),
              32'({exp_addr[3], exp_addr[2], exp_addr[1], exp_addr[0]}));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) exp_addr[i] = '0;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        req      = '0;
        req_reg  = '0;
        req_addr = '0;
        for (int r = 0; r < 4; r++) begin
            exp_addr[r] = '0;
            for (int a = 0; a < 32; a++) mem[r][a] = 4'((r * 7 + a * 3 + 5) & 15);
        end
        mem[2][5]     = 4'hA;
        mem[3][5'h12] = 4'h7;

        vecs[0] = '{0, 2'd2, 5'h05, 4'h0, 1'b0};
        vecs[1] = '{1, 2'd3, 5'h12, 4'h0, 1'b0};
        vecs[2] = '{0, 2'd1, 5'h15, 4'h0, 1'b1};
        vecs[3] = '{1, 2'd0, 5'h0F, 4'h0, 1'b0};
        vecs[4] = '{0, 2'd3, 5'h13, 4'h0, 1'b0};
        vecs[5] = '{1, 2'd2, 5'h14, 4'h0, 1'b1};
        vecs[6] = '{1, 2'd1, 5'h1F, 4'h0, 1'b1};
        vecs[7] = '{0, 2'd0, 5'h00, 4'h0, 1'b0};
        for (int i = 0; i < 8; i++) vecs[i].exp_data = model(vecs[i].rreg, vecs[i].addr);
        check("tbl_single_data", 32'(vecs[0].exp_data), 32'hA);

        #12;
        check("reset_outputs", 32'({gnt, rd_valid, rd_data, rd_id, rd_err, busy}), 32'h0);
        check_ports("reset_ports");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single-requester vectors; the idle requester's fields carry junk.
        for (int i = 0; i < 8; i++) begin
            req_reg  = 4'($urandom);
            req_addr = 10'($urandom);
            req_reg[2*vecs[i].id +: 2]  = vecs[i].rreg;
            req_addr[5*vecs[i].id +: 5] = vecs[i].addr;
            req = 2'(1 << vecs[i].id);
            tick();
            check("vec_gnt", 32'(gnt), 32'(1 << vecs[i].id));
            check("vec_busy", 32'(busy), 32'h1);
            begin
                exp_t e;
                e.id   = 2'(vecs[i].id);
                e.data = vecs[i].exp_data;
                e.err  = vecs[i].exp_err;
                sb.push_back(e);
            end
            exp_addr[vecs[i].rreg] = vecs[i].addr;
            check_ports("vec_ports");
            req = '0;
            tick();
            check("vec_idle", 32'({gnt, busy}), 32'h0);
            tick();
        end

        // Fairness: both requesters held, grants alternate starting at requester 0.
        do_reset();
        req_reg  = {2'd1, 2'd0};
        req_addr = {5'h07, 5'h03};
        req      = 2'b11;
        for (int i = 0; i < 6; i++) begin
            int w;
            tick();
            w = i % 2;
            check("fair_gnt", 32'(gnt), 32'(1 << w));
            if (i > 0) check("fair_rd_valid", 32'(rd_valid), 32'h1);
            push(w, (w == 0) ? 2'd0 : 2'd1, (w == 0) ? 5'h03 : 5'h07);
            check_ports("fair_ports");
        end
        req = '0;
        tick();
        tick();
        tick();
        check("fair_idle", 32'(busy), 32'h0);

        // Back-to-back mask: requester 0 alone for three edges gets edges 0 and 2.
        req_reg  = {2'd0, 2'd2};
        req_addr = {5'h00, 5'h09};
        req      = 2'b01;
        tick();
        check("mask_gnt_e0", 32'(gnt), 32'h1);
        push(0, 2'd2, 5'h09);
        tick();
        check("mask_gnt_e1", 32'(gnt), 32'h0);
        tick();
        check("mask_gnt_e2", 32'(gnt), 32'h1);
        push(0, 2'd2, 5'h09);
        req = '0;
        tick();
        check("mask_gnt_e3", 32'(gnt), 32'h0);
        tick();
        tick();

        // Async reset between grant and capture discards the read and rewinds last.
        req_reg  = {2'd3, 2'd1};
        req_addr = {5'h11, 5'h02};
        req      = 2'b01;
        tick();
        check("rst_gnt", 32'(gnt), 32'h1);
        req = '0;
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_outputs", 32'({gnt, rd_valid, rd_data, rd_id, rd_err, busy}), 32'h0);
        for (int i = 0; i < 4; i++) exp_addr[i] = '0;
        check_ports("rst_async_ports");
        tick();
        reset = 1'b0;
        tick();
        req = 2'b11;
        tick();
        check("rst_first_gnt", 32'(gnt), 32'h1);
        push(0, 2'd1, 5'h02);
        req = 2'b10;
        tick();
        check("rst_second_gnt", 32'(gnt), 32'h2);
        push(1, 2'd3, 5'h11);
        check_ports("rst_ports");
        req = '0;
        tick();
        tick();
        tick();

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i4002_rd_arbiter.md
# i4002_rd_arbiter

Round-robin arbiter that shares the four secondary read ports (`ramN_addr2` / `ramN_data2_out`) of one i4002 among up to four requesters, such as a display scanner, a debug/host reader and a trace capture unit. It sits beside the i4002 instance in the system top. It accepts request/address pairs, sequences one read per grant, and returns tagged 4-bit read data. It never touches the MCS-4 bus side of the chip.

## Interface
- `NUM_REQ`, 2: number of requesters, legal range 1..4.
- `RAM_ARRAY_SIZE`, 32: RAM depth per register array. Addresses at or above this value are out of range.
- `sysclk` in 1: the single clock. All state changes on its rising edge.
- `reset` in 1: reset, asynchronous and active-high. Clears all state immediately.
- `req` in NUM_REQ: per-requester request level. Must be held until the matching `gnt` bit is seen.
- `req_reg` in 2*NUM_REQ: per-requester register array select (0..3). Requester i uses bits [2i+1:2i].
- `req_addr` in 5*NUM_REQ: per-requester RAM address. Requester i uses bits [5i+4:5i]. 0x00–0x0F are main characters; 0x10–0x13 are status characters.
- `gnt` out NUM_REQ: one-cycle grant pulse, one-hot.
- `rd_valid` out 1: one-cycle pulse that qualifies `rd_data`, `rd_id` and `rd_err`.
- `rd_data` out 4: read data.
- `rd_id` out 2: index of the requester that owns the current `rd_valid`.
- `rd_err` out 1: set for an out-of-range address. In that case `rd_data` is 0.
- `busy` out 1: high while the FSM is in READ.
- `ram0_addr2`..`ram3_addr2` out 5 each: address to the i4002 secondary read ports.
- `ram0_data2_out`..`ram3_data2_out` in 4 each: combinational read data returned from those ports.

## Operation
- FSM states are IDLE and READ. Reset forces IDLE.
- **IDLE:**
  - If any eligible `req` bit is set, the arbiter picks a winner W by round-robin.
  - On that edge it registers `gnt[W]`=1, `ram{req_reg[W]}_addr2`=`req_addr[W]`, `sel_reg`, `sel_id`=W and `sel_err`=(`req_addr[W]` >= RAM_ARRAY_SIZE), then moves to READ.
- **READ:**
  - On the next edge the arbiter captures `ram{sel_reg}_data2_out` into `rd_data`, or 0 if `sel_err` is set.
  - On the same edge it sets `rd_valid`=1, `rd_id`=`sel_id` and `rd_err`=`sel_err`.
  - If an eligible request is pending, it grants it on that same edge and stays in READ. Otherwise it returns to IDLE.
- **Eligibility:** a `req[i]` sampled while `gnt[i]` is high is masked. A requester therefore gets at most one grant every two cycles. Other requesters may take back-to-back grants.
- **Round-robin order:**
  - A pointer `last` holds the index of the most recent winner. Reset value is NUM_REQ-1, so requester 0 wins first after reset.
  - The search order is `last`+1, `last`+2, … modulo NUM_REQ.
- **Port drive:**
  - Only the selected `ramN_addr2` port changes on a grant.
  - The other three ports hold their last value, so any concurrent static observation of them stays stable.
- **Requester changes:**
  - A `req` dropped before its grant is simply not served.
  - A `req` dropped after its grant has no effect; the read completes and `rd_valid` still fires.
- **`sel_reg` hold:** `req_reg` and `req_addr` are sampled only at the grant edge. `sel_reg` cannot change during READ.
- **Reset mid-read:** an in-flight read is discarded, no `rd_valid` is issued, and `last` returns to NUM_REQ-1.

## Timing
- Reset values: `gnt`=0, `rd_valid`=0, `rd_data`=0, `rd_id`=0, `rd_err`=0, `busy`=0, all `ramN_addr2`=0.
- **Latency:** if `req` is sampled high at edge E, `gnt` is high in cycle E..E+1, `rd_valid` in cycle E+1..E+2, and `busy` is high from E until the edge that returns the FSM to IDLE.
- **Throughput:** one read per cycle while eligible requests remain.
- All outputs are registered. There is no combinational path from `req` to `gnt`.
- The read path is combinational: `ramN_data2_out` must settle within one `sysclk` period after `ramN_addr2` changes. This holds for distributed RAM.

## Structure
- A shared package `i4002_pkg` holds:
  - `RAM_ADDR_W`=5, `RAM_DATA_W`=4, `NUM_REGS`=4;
  - `STATUS_BASE`=5'h10;
  - the FSM state enum {IDLE, READ}.
- One sub-module, `rr_arbiter`: a parameterised round-robin picker. Inputs are the eligible request vector and `last`; outputs are a one-hot winner and a valid flag. It is purely combinational, and the top block owns the `last` register.

## Test plan
- **Single read:** preload ram2[0x05]=0xA; requester 0 asserts with reg=2, addr=0x05 at edge 0. Required: `gnt`=01 in cycle 0–1, `ram2_addr2`=0x05, `rd_valid` with `rd_data`=0xA and `rd_id`=0 in cycle 1–2, `rd_err`=0, FSM back in IDLE.
- **Fairness:** requesters 0 and 1 both held high continuously with NUM_REQ=2. Required: grant sequence 0,1,0,1…, one `rd_valid` per cycle after the first, `rd_id` alternating.
- **Status row:** requester 1 reads reg=3, addr=0x12 with ram3[0x12]=0x7. Required: `ram3_addr2`=0x12, `rd_data`=0x7, `ram0/1/2_addr2` unchanged.
- **Out of range:** with RAM_ARRAY_SIZE=20, a request for addr=0x15. Required: `rd_valid`=1, `rd_err`=1, `rd_data`=0x0.
- **Back-to-back mask:** requester 0 holds `req` for three cycles alone. Required: grants at edges 0 and 2 only, two `rd_valid` pulses.
- **Async reset:** assert `reset` between grant and capture. Required: all outputs 0 immediately, no `rd_valid`, and the next request from requester 0 is granted first.
